// File: rtl/fork_join_sequencer.sv
// fork_join_sequencer
//   Cycle-accurate replacement for a fork/join/sequential delay schedule.
//   On start: immediate load of seq0, two independent delayed loads (para,
//   parb) running in parallel, a join once both have fired, then a final
//   delayed load of seq1.
//
// Ports
//   clk, rstn            : rising-edge clock, async active-low reset
//   start                : launch request, honoured only in IDLE
//   val_s0/pa/pb/s1      : load values (captured at launch)
//   dly_a/b/s1           : delays in cycles (captured at launch)
//   seq0_o/para_o/parb_o/seq1_o : registered load results
//   stb_o[3:0]           : one-cycle load strobes {seq1, parb, para, seq0}
//   busy_o               : high while in FORK or SEQ
//   done_o               : one-cycle pulse on the seq1 load edge
module fork_join_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] val_s0,
    input  logic [WIDTH-1:0] val_pa,
    input  logic [WIDTH-1:0] val_pb,
    input  logic [WIDTH-1:0] val_s1,
    input  logic [CNT_W-1:0] dly_a,
    input  logic [CNT_W-1:0] dly_b,
    input  logic [CNT_W-1:0] dly_s1,
    output logic [WIDTH-1:0] seq0_o,
    output logic [WIDTH-1:0] para_o,
    output logic [WIDTH-1:0] parb_o,
    output logic [WIDTH-1:0] seq1_o,
    output logic [3:0]       stb_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, FORK, SEQ} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d, c_q, c_d;
    logic             a_done_q, a_done_d, b_done_q, b_done_d;
    logic [WIDTH-1:0] vpa_q, vpa_d, vpb_q, vpb_d, vs1_q, vs1_d;
    logic [CNT_W-1:0] da_q, da_d, db_q, db_d, ds_q, ds_d;
    logic [WIDTH-1:0] seq0_q, seq0_d, para_q, para_d, parb_q, parb_d, seq1_q, seq1_d;
    logic [3:0]       stb_q, stb_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        c_d      = c_q;
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        vpa_d    = vpa_q;
        vpb_d    = vpb_q;
        vs1_d    = vs1_q;
        da_d     = da_q;
        db_d     = db_q;
        ds_d     = ds_q;
        seq0_d   = seq0_q;
        para_d   = para_q;
        parb_d   = parb_q;
        seq1_d   = seq1_q;
        stb_d    = 4'b0000;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vpa_d    = val_pa;
                    vpb_d    = val_pb;
                    vs1_d    = val_s1;
                    da_d     = dly_a;
                    db_d     = dly_b;
                    ds_d     = dly_s1;
                    seq0_d   = val_s0;
                    stb_d[0] = 1'b1;
                    t_d      = ONE;
                    // Zero-delay branches complete on the launch edge itself.
                    a_done_d = (dly_a == '0);
                    b_done_d = (dly_b == '0);
                    if (a_done_d) begin
                        para_d   = val_pa;
                        stb_d[1] = 1'b1;
                    end
                    if (b_done_d) begin
                        parb_d   = val_pb;
                        stb_d[2] = 1'b1;
                    end
                    if (a_done_d && b_done_d) begin
                        if (dly_s1 == '0) begin
                            seq1_d   = val_s1;
                            stb_d[3] = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            c_d     = ONE;
                            state_d = SEQ;
                        end
                    end else begin
                        state_d = FORK;
                    end
                end
            end

            FORK: begin
                if (!a_done_q && t_q == da_q) begin
                    para_d   = vpa_q;
                    stb_d[1] = 1'b1;
                    a_done_d = 1'b1;
                end
                if (!b_done_q && t_q == db_q) begin
                    parb_d   = vpb_q;
                    stb_d[2] = 1'b1;
                    b_done_d = 1'b1;
                end
                if (a_done_d && b_done_d) begin
                    // Join edge: t stops here so it never passes the larger delay.
                    if (ds_q == '0) begin
                        seq1_d   = vs1_q;
                        stb_d[3] = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        c_d     = ONE;
                        state_d = SEQ;
                    end
                end else begin
                    t_d = t_q + ONE;
                end
            end

            SEQ: begin
                if (c_q == ds_q) begin
                    seq1_d   = vs1_q;
                    stb_d[3] = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    c_d = c_q + ONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            t_q      <= '0;
            c_q      <= '0;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            vpa_q    <= '0;
            vpb_q    <= '0;
            vs1_q    <= '0;
            da_q     <= '0;
            db_q     <= '0;
            ds_q     <= '0;
            seq0_q   <= '0;
            para_q   <= '0;
            parb_q   <= '0;
            seq1_q   <= '0;
            stb_q    <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            c_q      <= c_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
            vpa_q    <= vpa_d;
            vpb_q    <= vpb_d;
            vs1_q    <= vs1_d;
            da_q     <= da_d;
            db_q     <= db_d;
            ds_q     <= ds_d;
            seq0_q   <= seq0_d;
            para_q   <= para_d;
            parb_q   <= parb_d;
            seq1_q   <= seq1_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
        end
    end

    assign seq0_o = seq0_q;
    assign para_o = para_q;
    assign parb_o = parb_q;
    assign seq1_o = seq1_q;
    assign stb_o  = stb_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule
